// File: rtl/dsp_issue_ctrl.sv
// Issue sequencer for the fractured-multiplier DSP: holds operands for the
// mode-dependent issue length, tracks the fixed output latency and buffers results.
module dsp_issue_ctrl #(
    parameter int unsigned N     = 16,
    parameter int unsigned M     = 16,
    parameter int unsigned LAT   = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [M-1:0]   in_b,
    input  logic [N+M-1:0] in_c,
    input  logic [1:0]     in_mode,
    input  logic           in_mac,
    input  logic [1:0]     in_shift,
    output logic           dsp_start,
    output logic [1:0]     dsp_mode,
    output logic [N-1:0]   dsp_aa,
    output logic [M-1:0]   dsp_bb,
    output logic [N+M-1:0] dsp_cc,
    output logic           dsp_mac,
    output logic [1:0]     dsp_barrel_shifter,
    input  logic [N+M-1:0] dsp_out,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [N+M-1:0] res_data,
    output logic           busy
);
    localparam int unsigned W  = N + M;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t         r_state, w_state_nxt;
    logic [1:0]     r_k, w_k_nxt;
    logic [2:0]     r_ncyc, w_ncyc_nxt;
    logic [CW-1:0]  r_credits, w_credits_nxt;
    logic [CW-1:0]  r_count;
    logic [LAT-1:0] r_tag;
    logic [W-1:0]   r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr, r_rd_ptr;
    logic           r_in_ready, r_start, r_mac;
    logic [1:0]     r_mode, r_shift;
    logic [N-1:0]   r_aa;
    logic [M-1:0]   r_bb;
    logic [W-1:0]   r_cc;
    logic           w_accept, w_last, w_push, w_pop, w_res_valid;

    function automatic logic [2:0] f_ncyc(input logic [1:0] mode);
        case (mode)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    assign w_last      = (r_state == S_RUN) && (r_k == 2'(r_ncyc - 3'd1));
    assign w_accept    = in_valid && r_in_ready;
    assign w_push      = r_tag[LAT-1];
    assign w_res_valid = (r_count != '0);
    assign w_pop       = w_res_valid && res_ready;

    // Next issue state; in_ready is registered from these next values.
    always_comb begin
        w_state_nxt   = r_state;
        w_k_nxt       = r_k;
        w_ncyc_nxt    = r_ncyc;
        w_credits_nxt = r_credits + CW'(w_accept) - CW'(w_pop);
        if (w_accept) begin
            w_state_nxt = S_RUN;
            w_k_nxt     = 2'd0;
            w_ncyc_nxt  = f_ncyc(in_mode);
        end else if (w_last) begin
            w_state_nxt = S_IDLE;
        end else if (r_state == S_RUN) begin
            w_k_nxt = r_k + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_ncyc     <= 3'd1;
            r_credits  <= '0;
            r_count    <= '0;
            r_tag      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_in_ready <= 1'b0;
            r_start    <= 1'b0;
            r_mac      <= 1'b0;
            r_mode     <= '0;
            r_shift    <= '0;
            r_aa       <= '0;
            r_bb       <= '0;
            r_cc       <= '0;
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_k        <= w_k_nxt;
            r_ncyc     <= w_ncyc_nxt;
            r_credits  <= w_credits_nxt;
            r_in_ready <= (w_credits_nxt < CW'(DEPTH)) &&
                          ((w_state_nxt == S_IDLE) || (w_k_nxt == 2'(w_ncyc_nxt - 3'd1)));
            r_start    <= w_accept;
            if (w_accept) begin
                r_aa    <= in_a;
                r_bb    <= in_b;
                r_cc    <= in_c;
                r_mac   <= in_mac;
                r_shift <= in_shift;
                r_mode  <= (in_mode == 2'd3) ? 2'd2 : in_mode;
            end
            // One tag per operation leaves the pipe when its dsp_out is valid.
            r_tag <= LAT'({r_tag, w_last});
            if (w_push) begin
                r_mem[r_wr_ptr] <= dsp_out;
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign in_ready           = r_in_ready;
    assign dsp_start          = r_start;
    assign dsp_mode           = r_mode;
    assign dsp_aa             = r_aa;
    assign dsp_bb             = r_bb;
    assign dsp_cc             = r_cc;
    assign dsp_mac            = r_mac;
    assign dsp_barrel_shifter = r_shift;
    assign res_valid          = w_res_valid;
    assign res_data           = r_mem[r_rd_ptr];
    assign busy               = (r_credits != '0);

endmodule

// File: tb/tb_dsp_issue_ctrl.sv
// Bench for dsp_issue_ctrl: DSP stub plus cycle-level reference model of
// acceptance, issue timing and result ordering, with directed and random stimulus.
module tb_dsp_issue_ctrl;
    localparam int unsigned N = 16, M = 16, LAT = 3, DEPTH = 4;
    localparam int unsigned W = N + M;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0, in_ready;
    logic [N-1:0] in_a = '0;
    logic [M-1:0] in_b = '0;
    logic [W-1:0] in_c = '0;
    logic [1:0]   in_mode = '0, in_shift = '0;
    logic         in_mac = 1'b0;
    logic         dsp_start, dsp_mac;
    logic [1:0]   dsp_mode, dsp_barrel_shifter;
    logic [N-1:0] dsp_aa;
    logic [M-1:0] dsp_bb;
    logic [W-1:0] dsp_cc, dsp_out = '0, res_data;
    logic         res_valid, res_ready = 1'b0, busy;

    always #5 clk = ~clk;

    dsp_issue_ctrl #(.N(N), .M(M), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .in_mode(in_mode), .in_mac(in_mac), .in_shift(in_shift),
        .dsp_start(dsp_start), .dsp_mode(dsp_mode),
        .dsp_aa(dsp_aa), .dsp_bb(dsp_bb), .dsp_cc(dsp_cc),
        .dsp_mac(dsp_mac), .dsp_barrel_shifter(dsp_barrel_shifter),
        .dsp_out(dsp_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
    );

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int ncyc(input logic [1:0] mode);
        return (mode == 2'd0) ? 1 : (mode == 2'd1) ? 2 : 4;
    endfunction

    // Behaviour assumed for the DSP itself; shared by stub and scoreboard.
    function automatic logic [W-1:0] dsp_fn(input logic [N-1:0] a, input logic [M-1:0] b,
                                            input logic [W-1:0] c, input logic mac,
                                            input logic [1:0] sh, input logic [W-1:0] prev);
        logic [W-1:0] sum;
        sum = (mac ? prev : c) + W'(a) * W'(b);
        return sum << sh;
    endfunction

    typedef struct { int at; logic [W-1:0] val; } res_t;

    res_t         rq[$];
    res_t         sq[$];
    int           next_ok = 0, credits = 0, start_cyc = -1, st_rem = 0;
    bit           was_rst = 1'b1;
    logic [N-1:0] cur_a = '0, st_a = '0;
    logic [M-1:0] cur_b = '0, st_b = '0;
    logic [W-1:0] cur_c = '0, st_c = '0, m_prev = '0, st_prev = '0;
    logic         cur_mac = 1'b0, st_mac = 1'b0;
    logic [1:0]   cur_mode = '0, cur_shift = '0, st_shift = '0;

    // Reference model evaluated once per cycle at the falling edge.
    task automatic model();
        bit           exp_rdy, exp_val;
        int           n;
        logic [W-1:0] v;
        if (reset) begin
            rq.delete(); sq.delete();
            credits = 0; start_cyc = -1; st_rem = 0; was_rst = 1'b1;
            cur_a = '0; cur_b = '0; cur_c = '0; cur_mac = 1'b0; cur_mode = '0; cur_shift = '0;
            m_prev = '0; st_prev = '0;
            dsp_out = $urandom;
            return;
        end
        if (was_rst) begin next_ok = cyc + 1; was_rst = 1'b0; end
        exp_rdy = (cyc >= next_ok) && (credits < int'(DEPTH));
        exp_val = (rq.size() > 0) && (rq[0].at <= cyc);
        check("in_ready", in_ready, exp_rdy);
        check("dsp_start", dsp_start, cyc == start_cyc);
        check("dsp_aa", dsp_aa, cur_a);
        check("dsp_bb", dsp_bb, cur_b);
        check("dsp_cc", dsp_cc, cur_c);
        check("dsp_mac", dsp_mac, cur_mac);
        check("dsp_shift", dsp_barrel_shifter, cur_shift);
        check("dsp_mode", dsp_mode, (cur_mode == 2'd3) ? 2'd2 : cur_mode);
        check("res_valid", res_valid, exp_val);
        if (exp_val) check("res_data", res_data, rq[0].val);
        check("busy", busy, credits != 0);
        if (in_valid && exp_rdy) begin
            n = ncyc(in_mode);
            v = dsp_fn(in_a, in_b, in_c, in_mac, in_shift, m_prev);
            m_prev = v;
            rq.push_back('{cyc + n + int'(LAT) + 1, v});
            next_ok = cyc + n; start_cyc = cyc + 1; credits++;
            cur_a = in_a; cur_b = in_b; cur_c = in_c;
            cur_mac = in_mac; cur_mode = in_mode; cur_shift = in_shift;
        end
        if (exp_val && res_ready) begin void'(rq.pop_front()); credits--; end
        // DSP stub: result valid exactly LAT cycles after the last issue cycle.
        if (dsp_start) begin
            st_rem = ncyc(dsp_mode);
            st_a = dsp_aa; st_b = dsp_bb; st_c = dsp_cc; st_mac = dsp_mac; st_shift = dsp_barrel_shifter;
        end
        if (st_rem > 0) begin
            st_rem--;
            if (st_rem == 0) begin
                v = dsp_fn(st_a, st_b, st_c, st_mac, st_shift, st_prev);
                st_prev = v;
                sq.push_back('{cyc + int'(LAT), v});
            end
        end
        if (sq.size() > 0 && sq[0].at == cyc) begin
            dsp_out = sq[0].val;
            void'(sq.pop_front());
        end else begin
            dsp_out = $urandom;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_req(input logic [N-1:0] a, input logic [M-1:0] b, input logic [W-1:0] c,
                           input logic [1:0] mode);
        in_a = a; in_b = b; in_c = c; in_mode = mode; in_mac = 1'b0; in_shift = '0;
        in_valid = 1'b1;
    endtask

    task automatic idle_wait();
        in_valid = 1'b0; res_ready = 1'b1;
        for (int i = 0; i < 80 && busy; i++) step();
        check("drain_idle", busy, 1'b0);
        step();
        res_ready = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!res_valid && n < 40) begin step(); n++; end
        check("valid_seen", res_valid, 1'b1);
    endtask

    task automatic directed(input string tag, input logic [N-1:0] a, input logic [M-1:0] b,
                            input logic [1:0] mode, input logic [W-1:0] exp_v, input int exp_lat);
        int n;
        idle_wait();
        check({tag, "_rdy"}, in_ready, 1'b1);
        set_req(a, b, '0, mode);
        step();
        in_valid = 1'b0;
        n = 1;
        while (!res_valid && n < 40) begin
            if (mode != 2'd0 && n < ncyc(mode)) check({tag, "_busyrdy"}, in_ready, 1'b0);
            step(); n++;
        end
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_data"}, res_data, exp_v);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, acc;
        step(); step();
        reset = 1'b0;
        step();
        check("reset_busy", busy, 1'b0);

        directed("m0", 16'h0012, 16'h0034, 2'd0, 32'h0000_03A8, 1 + int'(LAT) + 1);
        directed("m2", 16'h1234, 16'h5678, 2'd2, 32'h0626_0060, 4 + int'(LAT) + 1);
        directed("m3", 16'h0003, 16'h0004, 2'd3, 32'h0000_000C, 4 + int'(LAT) + 1);

        // Back-to-back mode 1 operations.
        idle_wait();
        set_req(16'h0100, 16'h0003, '0, 2'd1);
        step();
        set_req(16'h0002, 16'h0005, '0, 2'd1);
        check("b2b_rdy_mid", in_ready, 1'b0);
        step();
        check("b2b_rdy_last", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        check("b2b_start2", dsp_start, 1'b1);
        wait_valid(n);
        check("b2b_first", res_data, 32'h0000_0300);
        res_ready = 1'b1; step(); res_ready = 1'b0;
        wait_valid(n);
        check("b2b_second", res_data, 32'h0000_000A);
        res_ready = 1'b1; step(); res_ready = 1'b0;

        // Credit limit with the consumer stalled.
        idle_wait();
        acc = 0;
        set_req(16'($urandom), 16'($urandom), W'($urandom), 2'd0);
        for (int i = 0; i < 20; i++) begin
            bit took;
            took = in_valid && in_ready;
            if (took) acc++;
            step();
            if (took) begin
                in_a = 16'($urandom); in_b = 16'($urandom); in_c = W'($urandom);
                if (acc == 6) in_valid = 1'b0;
            end
        end
        check("fill_acc", acc, 4);
        check("fill_rdy", in_ready, 1'b0);
        in_valid = 1'b0;
        idle_wait();
        check("fill_resume", in_ready, 1'b1);

        // Reset in the middle of a mode 2 issue.
        set_req(16'hBEEF, 16'h1357, 32'h1111_2222, 2'd2);
        step();
        in_valid = 1'b0;
        step(); step();
        reset = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_start", dsp_start, 1'b0);
        check("rst_aa", dsp_aa, '0);
        check("rst_bb", dsp_bb, '0);
        check("rst_cc", dsp_cc, '0);
        check("rst_mode", dsp_mode, '0);
        check("rst_mac", dsp_mac, 1'b0);
        check("rst_shift", dsp_barrel_shifter, '0);
        check("rst_valid", res_valid, 1'b0);
        check("rst_data", res_data, '0);
        check("rst_busy", busy, 1'b0);
        step(); step();
        reset = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        directed("post_rst", 16'h0007, 16'h0009, 2'd0, 32'h0000_003F, 1 + int'(LAT) + 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            in_a      = 16'($urandom);
            in_b      = 16'($urandom);
            in_c      = W'($urandom);
            in_mode   = 2'($urandom_range(0, 3));
            in_mac    = ($urandom_range(0, 3) == 0);
            in_shift  = 2'($urandom_range(0, 3));
            res_ready = ($urandom_range(0, 9) < 5);
            step();
        end
        idle_wait();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
